// File: rtl/iter_key_mixer.sv
// rtl/iter_key_mixer.sv - iterative key/state mixing engine, one round per clock
//
// Accepts one {key, state} pair over in_valid/in_ready, runs ROUNDS rounds of
// st <= rotl(st,1) ^ rk(rnd), then presents the result over out_valid/out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   key/state presented
//   in_ready   engine idle, can accept an operation
//   key        KEY_W key, sampled on acceptance
//   state      STATE_W initial state, sampled on acceptance
//   out_valid  result available
//   out_ready  consumer takes the result
//   out        STATE_W mixed state
//   busy       rounds in progress
//
// Build option: ITER_MIXER_KEY_ROLL_EN - round key is the low key slice and
// the key register rotates left by one bit each round.

module iter_key_mixer #(
    parameter int KEY_W   = 256,
    parameter int STATE_W = 128,
    parameter int ROUNDS  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [KEY_W-1:0]   key,
    input  logic [STATE_W-1:0] state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out,
    output logic               busy
);

    localparam int N     = KEY_W / STATE_W;
    localparam int RND_W = $clog2(ROUNDS + 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm;
    fsm_t               fsm_nxt;
    logic [KEY_W-1:0]   key_reg;
    logic [STATE_W-1:0] st;
    logic [STATE_W-1:0] st_nxt;
    logic [STATE_W-1:0] rk;
    logic [RND_W-1:0]   rnd;

    // Round key and next state for the current round
    always_comb begin
        rk = '0;
`ifdef ITER_MIXER_KEY_ROLL_EN
        rk = key_reg[STATE_W-1:0];
`else
        // Slice 0 is the LSB slice; the slice index wraps modulo N
        rk = key_reg[(int'(rnd) % N) * STATE_W +: STATE_W];
`endif
        st_nxt = {st[STATE_W-2:0], st[STATE_W-1]} ^ rk;
    end

    // Next-state and handshake outputs
    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (rnd == LAST_RND) fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
            st      <= '0;
            rnd     <= '0;
            out     <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        key_reg <= key;
                        st      <= state;
                        rnd     <= '0;
                    end
                end
                RUN: begin
                    st  <= st_nxt;
                    rnd <= rnd + 1'b1;
`ifdef ITER_MIXER_KEY_ROLL_EN
                    key_reg <= {key_reg[KEY_W-2:0], key_reg[KEY_W-1]};
`endif
                    // out only changes on the transition into DONE
                    if (rnd == LAST_RND) out <= st_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
